// File: rtl/mod_addsub_pipe.sv
// Two-stage modular add/subtract across LANES lanes sharing one modulus and op.
// Latency 2 cycles, one transaction per cycle; valid/ready backpressure stalls both stages.
// Optional operand range flag is built only when MOD_ADDSUB_RANGE_CHECK_EN is defined.
module mod_addsub_pipe #(
    parameter int BIT_WIDTH = 54,
    parameter int LANES     = 4,
    parameter int TAG_W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_op,
    input  logic [BIT_WIDTH-1:0]       in_q,
    input  logic [LANES*BIT_WIDTH-1:0] in_a,
    input  logic [LANES*BIT_WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*BIT_WIDTH-1:0] out_res,
    output logic [TAG_W-1:0]           out_tag,
    output logic                       err
);

    localparam int RW = BIT_WIDTH + 1;

    logic                       r_s1_vld;
    logic                       r_s1_op;
    logic [BIT_WIDTH-1:0]       r_s1_q;
    logic [LANES*RW-1:0]        r_s1_raw;
    logic [TAG_W-1:0]           r_s1_tag;

    logic                       r_s2_vld;
    logic [LANES*BIT_WIDTH-1:0] r_s2_res;
    logic [TAG_W-1:0]           r_s2_tag;

    logic                       w_s2_adv;
    logic                       w_s1_adv;
    logic                       w_accept;
    logic [LANES*RW-1:0]        w_raw;
    logic [LANES*BIT_WIDTH-1:0] w_fix;

    assign w_s2_adv  = !r_s2_vld || out_ready;
    assign w_s1_adv  = !r_s1_vld || w_s2_adv;
    assign w_accept  = in_valid && w_s1_adv;
    assign in_ready  = w_s1_adv;
    assign out_valid = r_s2_vld;
    assign out_res   = r_s2_res;
    assign out_tag   = r_s2_tag;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [RW-1:0]        w_a_ext;
        logic [RW-1:0]        w_b_ext;
        logic [RW-1:0]        w_lane_raw;
        logic [RW-1:0]        w_q_ext;
        logic [RW-1:0]        w_add_red;
        logic [BIT_WIDTH-1:0] w_sub_fix;

        assign w_a_ext = {1'b0, in_a[g*BIT_WIDTH +: BIT_WIDTH]};
        assign w_b_ext = {1'b0, in_b[g*BIT_WIDTH +: BIT_WIDTH]};
        assign w_raw[g*RW +: RW] = in_op ? (w_a_ext - w_b_ext) : (w_a_ext + w_b_ext);

        // Subtract borrow shows up as the extra top bit; adding q modulo 2^BIT_WIDTH repairs it.
        assign w_lane_raw = r_s1_raw[g*RW +: RW];
        assign w_q_ext    = {1'b0, r_s1_q};
        assign w_add_red  = (w_lane_raw >= w_q_ext) ? (w_lane_raw - w_q_ext) : w_lane_raw;
        assign w_sub_fix  = w_lane_raw[BIT_WIDTH] ? (w_lane_raw[BIT_WIDTH-1:0] + r_s1_q)
                                                  : w_lane_raw[BIT_WIDTH-1:0];
        assign w_fix[g*BIT_WIDTH +: BIT_WIDTH] = r_s1_op ? w_sub_fix : w_add_red[BIT_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_vld <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s1_op  <= in_op;
            r_s1_q   <= in_q;
            r_s1_raw <= w_raw;
            r_s1_tag <= in_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_vld <= 1'b0;
            r_s2_res <= '0;
            r_s2_tag <= '0;
        end else if (w_s2_adv) begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_res <= w_fix;
                r_s2_tag <= r_s1_tag;
            end
        end
    end

`ifdef MOD_ADDSUB_RANGE_CHECK_EN
    logic [LANES-1:0] w_oor;
    logic             r_err;

    for (genvar g = 0; g < LANES; g++) begin : g_chk
        assign w_oor[g] = (in_a[g*BIT_WIDTH +: BIT_WIDTH] >= in_q) ||
                          (in_b[g*BIT_WIDTH +: BIT_WIDTH] >= in_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_accept && (|w_oor)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mod_addsub_pipe.sv
module tb_mod_addsub_pipe;
    localparam int W  = 54;
    localparam int L  = 4;
    localparam int TW = 8;
    localparam logic [W-1:0] QD = 54'h3F_FFFF_FFFE_D001;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             in_op;
    logic [W-1:0]     in_q;
    logic [L*W-1:0]   in_a;
    logic [L*W-1:0]   in_b;
    logic [TW-1:0]    in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [L*W-1:0]   out_res;
    logic [TW-1:0]    out_tag;
    logic             err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [L*W-1:0] res;
        logic [TW-1:0]  tag;
    } exp_t;

    mod_addsub_pipe #(.BIT_WIDTH(W), .LANES(L), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_q(in_q),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_tag(out_tag), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_lane(input bit op, input logic [63:0] q,
                                             input logic [63:0] a, input logic [63:0] b);
        if (!op) return (a + b) % q;
        return (a + q - b) % q;
    endfunction

    function automatic logic [L*W-1:0] ref_vec(input bit op, input logic [W-1:0] q,
                                               input logic [L*W-1:0] a, input logic [L*W-1:0] b);
        logic [L*W-1:0] r;
        logic [63:0]    v;
        r = '0;
        for (int i = 0; i < L; i++) begin
            v = ref_lane(op, 64'(q), 64'(a[i*W +: W]), 64'(b[i*W +: W]));
            r[i*W +: W] = v[W-1:0];
        end
        return r;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic send_txn(input bit op, input logic [W-1:0] q, input logic [L*W-1:0] a,
                            input logic [L*W-1:0] b, input logic [TW-1:0] tag, output bit ok);
        in_valid = 1'b1; in_op = op; in_q = q; in_a = a; in_b = b; in_tag = tag;
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            if (ok) break;
        end
        in_valid = 1'b0;
    endtask

    task automatic get_result(output logic [L*W-1:0] res, output logic [TW-1:0] tag, output bit ok);
        out_ready = 1'b1;
        ok = 1'b0;
        res = 'x;
        tag = 'x;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1; res = out_res; tag = out_tag;
            end
            @(posedge clk); #1;
            if (ok) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_op = 1'b0; in_q = QD; in_a = '0; in_b = '0; in_tag = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_res !== '0) begin errors++; $display("FAIL reset_out_res got %h want 0", out_res); end
        checks++; if (out_tag !== '0) begin errors++; $display("FAIL reset_out_tag got %h want 0", out_tag); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_latency();
        in_valid = 1'b1; in_op = 1'b0; in_q = QD; in_a = '0; in_b = '0; in_tag = 8'h5A;
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL zero_accept got %b want 1", in_ready); end
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL zero_early_valid got %b want 0", out_valid); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL zero_latency got %b want 1", out_valid); end
        checks++; if (out_res !== '0) begin errors++; $display("FAIL zero_res got %h want 0", out_res); end
        checks++; if (out_tag !== 8'h5A) begin errors++; $display("FAIL zero_tag got %h want 5a", out_tag); end
        @(posedge clk); #1;
    endtask

    task automatic test_add_edge();
        logic [L*W-1:0] a, b, res;
        logic [TW-1:0]  tag;
        bit             ok;
        a = '0; b = '0;
        a[0 +: W] = QD - 1; b[0 +: W] = QD - 1;
        a[W +: W] = QD - 1; b[W +: W] = 1;
        send_txn(1'b0, QD, a, b, 8'h11, ok);
        get_result(res, tag, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL add_edge_timeout got %b want 1", ok); end
        checks++; if (res[0 +: W] !== QD - 2) begin errors++; $display("FAIL add_edge_lane0 got %h want %h", res[0 +: W], QD - 2); end
        checks++; if (res[W +: W] !== '0) begin errors++; $display("FAIL add_edge_lane1 got %h want 0", res[W +: W]); end
        checks++; if (tag !== 8'h11) begin errors++; $display("FAIL add_edge_tag got %h want 11", tag); end
    endtask

    task automatic test_sub_edge();
        logic [L*W-1:0] a, b, res, exp;
        logic [TW-1:0]  tag;
        bit             ok;
        a = '0; b = '0;
        b[0 +: W] = 1;
        a[W +: W] = 5; b[W +: W] = 5;
        a[2*W +: W] = 3; b[2*W +: W] = 9;
        exp = ref_vec(1'b1, QD, a, b);
        send_txn(1'b1, QD, a, b, 8'h22, ok);
        get_result(res, tag, ok);
        checks++; if (res[0 +: W] !== QD - 1) begin errors++; $display("FAIL sub_edge_lane0 got %h want %h", res[0 +: W], QD - 1); end
        checks++; if (res[W +: W] !== '0) begin errors++; $display("FAIL sub_edge_lane1 got %h want 0", res[W +: W]); end
        checks++; if (res !== exp) begin errors++; $display("FAIL sub_edge_all got %h want %h", res, exp); end
        checks++; if (tag !== 8'h22) begin errors++; $display("FAIL sub_edge_tag got %h want 22", tag); end
    endtask

    task automatic test_back_to_back();
        exp_t           expq[$];
        logic [L*W-1:0] a [3];
        logic [L*W-1:0] b;
        exp_t           e;
        int             sent, got;
        b = '0;
        for (int t = 0; t < 3; t++) begin
            a[t] = '0;
            for (int i = 0; i < L; i++) begin
                a[t][i*W +: W] = 54'((t + 1) * 10 + i);
                b[i*W +: W] = 7;
            end
            e.res = ref_vec(1'b0, QD, a[t], b);
            e.tag = 8'(t + 1);
            expq.push_back(e);
        end
        sent = 0; got = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 40 && got < 3; c++) begin
            if (c == 4) out_ready = 1'b1;
            in_valid = (sent < 3);
            in_op = 1'b0; in_q = QD; in_b = b;
            in_a = a[sent < 3 ? sent : 2];
            in_tag = 8'(sent + 1);
            @(negedge clk);
            if (c == 2) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_in_ready got %b want 0", in_ready); end
            end
            if (c == 2 || c == 3) begin
                checks++; if (out_valid !== 1'b1 || out_tag !== 8'd1) begin
                    errors++; $display("FAIL b2b_hold cycle %0d got valid %b tag %h want 1/01", c, out_valid, out_tag);
                end
            end
            if (out_valid && out_ready) begin
                e = expq.pop_front();
                checks++; if (out_tag !== e.tag) begin errors++; $display("FAIL b2b_tag got %h want %h", out_tag, e.tag); end
                checks++; if (out_res !== e.res) begin errors++; $display("FAIL b2b_res got %h want %h", out_res, e.res); end
                got++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++; if (got !== 3) begin errors++; $display("FAIL b2b_count got %0d want 3", got); end
    endtask

    task automatic test_reset_midflight();
        logic [L*W-1:0] one, res;
        logic [TW-1:0]  tag;
        bit             ok;
        int             seen;
        one = '0; one[0 +: W] = 1;
        out_ready = 1'b0;
        send_txn(1'b0, QD, one, one, 8'hA1, ok);
        send_txn(1'b0, QD, one, one, 8'hA2, ok);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        @(posedge clk); #1;
        checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_ghost got %0d outputs want 0", seen); end
        send_txn(1'b0, QD, one, one, 8'hB3, ok);
        get_result(res, tag, ok);
        checks++; if (tag !== 8'hB3) begin errors++; $display("FAIL midrst_next_tag got %h want b3", tag); end
        checks++; if (res[0 +: W] !== 54'd2) begin errors++; $display("FAIL midrst_next_res got %h want 2", res[0 +: W]); end
    endtask

    task automatic test_random();
        exp_t           expq[$];
        exp_t           e;
        logic [W-1:0]   q;
        logic [L*W-1:0] a, b, hold_res;
        logic [TW-1:0]  hold_tag;
        logic [63:0]    r;
        bit             acc, held;
        int             accepted, cycles;
        accepted = 0; cycles = 0; acc = 1'b0; held = 1'b0;
        in_valid = 1'b0;
        while ((accepted < 4096 || expq.size() > 0) && cycles < 30000) begin
            if (!in_valid || acc) begin
                if (accepted < 4096 && ($urandom % 5) != 0) begin
                    r = rand64();
                    q = (($urandom % 4) == 0) ? QD : r[W-1:0];
                    if (q < 2) q = 2;
                    for (int i = 0; i < L; i++) begin
                        r = rand64() % 64'(q); a[i*W +: W] = r[W-1:0];
                        r = rand64() % 64'(q); b[i*W +: W] = r[W-1:0];
                    end
                    if (($urandom % 8) == 0) b[0 +: W] = a[0 +: W];
                    in_valid = 1'b1; in_op = $urandom % 2; in_q = q;
                    in_a = a; in_b = b; in_tag = 8'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom % 4) != 0;
            @(negedge clk);
            if (held) begin
                checks++; if (out_valid !== 1'b1 || out_res !== hold_res || out_tag !== hold_tag) begin
                    errors++; $display("FAIL rand_hold got %b %h/%h want 1 %h/%h", out_valid, out_tag, out_res, hold_tag, hold_res);
                end
            end
            held = out_valid && !out_ready;
            hold_res = out_res; hold_tag = out_tag;
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    checks++; errors++; $display("FAIL rand_extra got tag %h want none", out_tag);
                end else begin
                    e = expq.pop_front();
                    checks++; if (out_tag !== e.tag) begin errors++; $display("FAIL rand_tag got %h want %h", out_tag, e.tag); end
                    checks++; if (out_res !== e.res) begin errors++; $display("FAIL rand_res got %h want %h", out_res, e.res); end
                end
            end
            acc = in_valid && in_ready;
            if (acc) begin
                e.res = ref_vec(in_op, in_q, in_a, in_b);
                e.tag = in_tag;
                expq.push_back(e);
                accepted++;
            end
            @(posedge clk); #1;
            cycles++;
        end
        in_valid = 1'b0;
        checks++; if (accepted !== 4096 || expq.size() !== 0) begin
            errors++; $display("FAIL rand_drain got %0d accepted %0d pending want 4096/0", accepted, expq.size());
        end
    endtask

    task automatic test_range();
        logic [L*W-1:0] a, b, res;
        logic [TW-1:0]  tag;
        bit             ok, exp_err;
`ifdef MOD_ADDSUB_RANGE_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        a = '0; b = '0;
        a[3*W +: W] = QD;
        send_txn(1'b0, QD, a, b, 8'hE0, ok);
        @(negedge clk);
        checks++; if (err !== exp_err) begin errors++; $display("FAIL range_err got %b want %b", err, exp_err); end
        get_result(res, tag, ok);
        checks++; if (ok !== 1'b1 || tag !== 8'hE0) begin errors++; $display("FAIL range_handshake got %b/%h want 1/e0", ok, tag); end
        a[3*W +: W] = 4; b[3*W +: W] = 6;
        send_txn(1'b1, QD, a, b, 8'hE1, ok);
        get_result(res, tag, ok);
        checks++; if (res[3*W +: W] !== QD - 2) begin errors++; $display("FAIL range_legal got %h want %h", res[3*W +: W], QD - 2); end
        @(negedge clk);
        checks++; if (err !== exp_err) begin errors++; $display("FAIL range_sticky got %b want %b", err, exp_err); end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL range_clear got %b want 0", err); end
    endtask

    initial begin
        test_reset();
        test_zero_latency();
        test_add_edge();
        test_sub_edge();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        test_range();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mod_addsub_pipe.md
MOD_ADDSUB_PIPE -- requirements
Module: mod_addsub_pipe

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 54: coefficient and modulus width.
REQ-002 SHALL have parameter LANES, default 4: number of independent coefficient lanes sharing one q and one op.
REQ-003 SHALL have parameter TAG_W, default 8: width of the opaque sideband tag carried with each transaction.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1: input transaction present.
REQ-007 SHALL have port in_ready, output, 1: block accepts the input this cycle.
REQ-008 SHALL have port in_op, input, 1: 0 = add, 1 = subtract.
REQ-009 SHALL have port in_q, input, BIT_WIDTH: modulus, sampled with the transaction.
REQ-010 SHALL have port in_a, input, LANES*BIT_WIDTH: operand a; lane i occupies bits [i*BIT_WIDTH +: BIT_WIDTH].
REQ-011 SHALL have port in_b, input, LANES*BIT_WIDTH: operand b, same packing as in_a.
REQ-012 SHALL have port in_tag, input, TAG_W: sideband tag.
REQ-013 SHALL have port out_valid, output, 1: result present.
REQ-014 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-015 SHALL have port out_res, output, LANES*BIT_WIDTH: per-lane result, same packing as in_a.
REQ-016 SHALL have port out_tag, output, TAG_W: tag of the presented result.
REQ-017 SHALL have port err, output, 1: sticky operand range error (see Configuration).

Function
REQ-018 SHALL accept a transaction on a cycle where in_valid and in_ready are both 1.
REQ-019 SHALL compute per lane: add gives (a+b) mod q; sub gives (a-b) mod q; both require a<q, b<q and 2<=q<2^BIT_WIDTH.
REQ-020 SHALL use a BIT_WIDTH+1 bit intermediate: add as sum, then subtract q when sum>=q; sub as a-b, then add q when it borrows; no division.
REQ-021 SHALL use two register stages: S1 holds the raw sum or difference plus q, op, tag and valid; S2 holds the corrected result, tag and valid.
REQ-022 SHALL raise out_valid on the 2nd rising edge after acceptance when there is no stall, and SHALL sustain throughput of one transaction per cycle.
REQ-023 SHALL advance S2 when S2 is empty or out_ready=1, and SHALL advance S1 when S1 is empty or S2 advances.
REQ-024 SHALL drive in_ready = !S1_valid || S2 advances, combinationally and without depending on in_valid.
REQ-025 SHALL hold out_res and out_tag stable while out_valid=1 and out_ready=0.
REQ-026 SHALL not drop, duplicate or reorder transactions; results leave in acceptance order.
REQ-027 SHALL treat simultaneous acceptance and drain in the same cycle as a pass-through, with no bubble.
REQ-028 SHALL produce an unspecified result for q outside its legal range or for operands >= q, but the handshake SHALL still complete.

Reset
REQ-029 SHALL, while rst=1, clear S1_valid, S2_valid, out_res, out_tag and err to 0 on the next rising edge.
REQ-030 SHALL discard in-flight transactions on reset mid-operation; none of them appear at the output afterwards.
REQ-031 SHALL, in the cycle after rst deasserts, present in_ready=1 and out_valid=0.

Configuration
REQ-032 SHALL, when macro MOD_ADDSUB_RANGE_CHECK_EN is defined, set err to 1 on the edge that accepts a transaction where any lane has a>=q or b>=q; err then stays 1 until reset.
REQ-033 SHALL, without MOD_ADDSUB_RANGE_CHECK_EN, tie err to constant 0 and include no comparison logic for it.

Verification (q = 0x3F_FFFF_FFFE_D001, BIT_WIDTH=54, LANES=4)
REQ-034 SHALL cover: add with a=b=0 on all lanes and out_ready=1 -> out_valid exactly 2 cycles after acceptance, every lane 0, tag echoed.
REQ-035 SHALL cover: add with lane0 a=b=q-1 and lane1 a=q-1, b=1 -> lane0 = q-2, lane1 = 0.
REQ-036 SHALL cover: sub with lane0 a=0, b=1 and lane1 a=b=5 -> lane0 = q-1, lane1 = 0.
REQ-037 SHALL cover: 3 back-to-back transactions with tags 1,2,3 and out_ready=0 for 4 cycles -> in_ready=0 once S1 and S2 are full, tag 1 is held stable, then tags 1,2,3 exit in order with no loss.
REQ-038 SHALL cover: rst pulsed for 1 cycle with 2 transactions in flight -> out_valid=0 from the next edge and neither result is ever output.
REQ-039 SHALL cover: a=q on lane 3 -> err=1 and it stays set until reset when MOD_ADDSUB_RANGE_CHECK_EN is defined, otherwise err=0; plus 4096 random add/sub transactions per lane with random out_ready checked against a (a±b) mod q reference model.
